// File: rtl/key_direction_ctrl.sv
// Pushbutton front end for snake_game: synchronises and debounces KEY2/KEY3, queues at most
// one turn per game step and commits it to the heading on the next game_tik rising edge.
module key_direction_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DEB_CNT_BIT     = 18,
    parameter logic [1:0]  INIT_DIR        = 2'b00
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       game_tik,
    input  logic       game_enable,
    input  logic       right_P,
    input  logic       left_P,
    output logic [1:0] direction,
    output logic       dir_update,
    output logic       turn_pending
);

    localparam logic [DEB_CNT_BIT-1:0] DEB_LAST = DEB_CNT_BIT'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPendR = 2'b01,
        StPendL = 2'b10
    } state_e;

    // Bit 0 is the right key, bit 1 the left key throughout.
    logic [1:0]             raw_keys;
    logic [1:0]             key_s1_q;
    logic [1:0]             key_s2_q;
    logic [1:0]             key_deb_q;
    logic [1:0]             key_deb_prev_q;
    logic [1:0]             key_arm_q;
    logic [1:0]             live_q;
    logic [DEB_CNT_BIT-1:0] deb_cnt_q [2];
    logic [2:0]             tik_q;
    logic [1:0]             press;
    logic                   tick_rise;
    state_e                 state_q;

    assign raw_keys = {left_P, right_P};

    // A key only arms once it has been seen released after reset, so a key held through
    // reset release needs a full release/press before it can queue a turn.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            key_s1_q       <= '1;
            key_s2_q       <= '1;
            key_deb_q      <= '1;
            key_deb_prev_q <= '1;
            key_arm_q      <= '0;
            live_q         <= '0;
            tik_q          <= '1;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            key_s1_q       <= raw_keys;
            key_s2_q       <= key_s1_q;
            key_deb_prev_q <= key_deb_q;
            live_q         <= {live_q[0], 1'b1};
            tik_q          <= {tik_q[1:0], game_tik};
            key_arm_q      <= key_arm_q | ({2{live_q[1]}} & key_s2_q);
            for (int i = 0; i < 2; i++) begin
                if (key_s2_q[i] == key_deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] >= DEB_LAST) begin
                    key_deb_q[i] <= key_s2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DEB_CNT_BIT'(1);
                end
            end
        end
    end

    assign press     = key_arm_q & key_deb_prev_q & ~key_deb_q;
    assign tick_rise = tik_q[1] & ~tik_q[2];

    // A press seen together with tick_rise in idle is queued for the following tick.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            direction    <= INIT_DIR;
            dir_update   <= 1'b0;
            turn_pending <= 1'b0;
        end else begin
            dir_update <= 1'b0;
            if (!game_enable) begin
                state_q      <= StIdle;
                turn_pending <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (press == 2'b01) begin
                            state_q      <= StPendR;
                            turn_pending <= 1'b1;
                        end else if (press == 2'b10) begin
                            state_q      <= StPendL;
                            turn_pending <= 1'b1;
                        end
                    end
                    StPendR: begin
                        if (tick_rise) begin
                            direction    <= direction + 2'd1;
                            dir_update   <= 1'b1;
                            state_q      <= StIdle;
                            turn_pending <= 1'b0;
                        end
                    end
                    StPendL: begin
                        if (tick_rise) begin
                            direction    <= direction - 2'd1;
                            dir_update   <= 1'b1;
                            state_q      <= StIdle;
                            turn_pending <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= StIdle;
                        turn_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_direction_ctrl.sv
// Directed bench for key_direction_ctrl: a per-cycle reference model of the key/tick rules is
// compared against the outputs every cycle, with literal checks at the key points of each scenario.
module tb_key_direction_ctrl;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_tik = 1'b0;
    logic       game_enable = 1'b1;
    logic       right_P = 1'b1;
    logic       left_P = 1'b1;
    logic [1:0] direction;
    logic       dir_update;
    logic       turn_pending;

    int checks = 0;
    int failures = 0;

    key_direction_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .DEB_CNT_BIT    (3),
        .INIT_DIR       (2'b00)
    ) dut (
        .clock_25    (clk),
        .reset       (rst_n),
        .game_tik    (game_tik),
        .game_enable (game_enable),
        .right_P     (right_P),
        .left_P      (left_P),
        .direction   (direction),
        .dir_update  (dir_update),
        .turn_pending(turn_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: heading and queued turn (0 none, 1 right, 2 left), plus recent raw
    // samples so that the synced view of an input is simply its value two clocks ago.
    int m_dir;
    int m_pend;
    bit m_upd;
    int m_n;
    bit rq[$];
    bit lq[$];
    bit tq[$];
    bit m_deb[2];
    int m_run[2];
    bit m_arm[2];
    bit ev_k[2];
    bit ev_tick;

    task automatic model_reset();
        m_dir = 0;
        m_pend = 0;
        m_upd = 0;
        m_n = 0;
        rq = {1'b1, 1'b1};
        lq = {1'b1, 1'b1};
        tq = {1'b1, 1'b1};
        ev_tick = 0;
        for (int k = 0; k < 2; k++) begin
            m_deb[k] = 1;
            m_run[k] = 0;
            m_arm[k] = 0;
            ev_k[k] = 0;
        end
    endtask

    always @(posedge clk) begin : model_step
        bit syn[2];
        if (!rst_n) begin
            model_reset();
        end else begin
            // Events decided on the previous clock act on the heading now.
            m_upd = 0;
            if (!game_enable) begin
                m_pend = 0;
            end else if (m_pend == 0) begin
                if (ev_k[0] && !ev_k[1]) m_pend = 1;
                else if (ev_k[1] && !ev_k[0]) m_pend = 2;
            end else if (ev_tick) begin
                m_dir = (m_pend == 1) ? (m_dir + 1) % 4 : (m_dir + 3) % 4;
                m_upd = 1;
                m_pend = 0;
            end
            m_n++;
            syn[0] = rq.pop_front();
            rq.push_back(right_P);
            syn[1] = lq.pop_front();
            lq.push_back(left_P);
            for (int k = 0; k < 2; k++) begin
                ev_k[k] = 0;
                if (m_n >= 3 && syn[k]) m_arm[k] = 1;
                if (syn[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == int'(D)) begin
                        m_deb[k] = syn[k];
                        m_run[k] = 0;
                        ev_k[k] = !syn[k] && m_arm[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            ev_tick = tq[1] && !tq[0];
            void'(tq.pop_front());
            tq.push_back(game_tik);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_direction", 8'(direction), 8'(m_dir));
        chk("model_dir_update", 8'(dir_update), 8'(m_upd));
        chk("model_turn_pending", 8'(turn_pending), 8'(m_pend != 0));
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick(output int pulses);
        pulses = 0;
        game_tik = 1'b1;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(dir_update);
        end
        game_tik = 1'b0;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(dir_update);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(5);
    endtask

    initial begin
        int pulses;
        int exp_left[4];
        exp_left = '{3, 2, 1, 0};

        // Reset held while keys chatter
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            right_P = i[0];
            left_P = ~i[0];
        end
        @(negedge clk);
        chk("reset_direction", 8'(direction), 8'd0);
        chk("reset_dir_update", 8'(dir_update), 8'd0);
        chk("reset_turn_pending", 8'(turn_pending), 8'd0);
        right_P = 1'b1;
        left_P = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(20);
        chk("idle_direction", 8'(direction), 8'd0);
        chk("idle_turn_pending", 8'(turn_pending), 8'd0);

        // Single right turn and its press latency
        right_P = 1'b0;
        wait_cycles(6);
        chk("latency_early", 8'(turn_pending), 8'd0);
        wait_cycles(1);
        chk("latency_exact", 8'(turn_pending), 8'd1);
        wait_cycles(3);
        right_P = 1'b1;
        wait_cycles(10);
        do_tick(pulses);
        chk("right_turn_dir", 8'(direction), 8'd1);
        chk("right_turn_pulses", 8'(pulses), 8'd1);
        chk("right_turn_cleared", 8'(turn_pending), 8'd0);

        // Bouncing key never settles long enough
        for (int i = 0; i < 15; i++) begin
            right_P = logic'(i % 2);
            wait_cycles(2);
        end
        right_P = 1'b1;
        wait_cycles(10);
        chk("bounce_no_pending", 8'(turn_pending), 8'd0);
        do_tick(pulses);
        chk("bounce_dir_held", 8'(direction), 8'd1);
        chk("bounce_no_pulse", 8'(pulses), 8'd0);

        // Four left turns wrap the heading round
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            left_P = 1'b0;
            wait_cycles(10);
            left_P = 1'b1;
            wait_cycles(10);
            do_tick(pulses);
            chk("left_wrap_dir", 8'(direction), 8'(exp_left[k]));
        end

        // Both keys in the same cycle are ignored
        right_P = 1'b0;
        left_P = 1'b0;
        wait_cycles(10);
        chk("both_no_pending", 8'(turn_pending), 8'd0);
        right_P = 1'b1;
        left_P = 1'b1;
        wait_cycles(10);
        do_tick(pulses);
        chk("both_dir_held", 8'(direction), 8'd0);

        // First press wins: left then right before the tick
        left_P = 1'b0;
        wait_cycles(10);
        chk("first_pending", 8'(turn_pending), 8'd1);
        left_P = 1'b1;
        right_P = 1'b0;
        wait_cycles(10);
        right_P = 1'b1;
        wait_cycles(10);
        do_tick(pulses);
        chk("first_wins_dir", 8'(direction), 8'd3);
        chk("first_wins_pulses", 8'(pulses), 8'd1);

        // Press coinciding with tick_rise waits for the next tick
        pulse_reset();
        right_P = 1'b0;
        wait_cycles(4);
        game_tik = 1'b1;
        wait_cycles(4);
        game_tik = 1'b0;
        chk("coincide_dir_held", 8'(direction), 8'd0);
        chk("coincide_pending", 8'(turn_pending), 8'd1);
        wait_cycles(2);
        right_P = 1'b1;
        wait_cycles(10);
        do_tick(pulses);
        chk("coincide_next_tick", 8'(direction), 8'd1);

        // Disable drops the queued turn; a key held across re-enable does nothing
        left_P = 1'b0;
        wait_cycles(8);
        chk("enable_pending", 8'(turn_pending), 8'd1);
        game_enable = 1'b0;
        wait_cycles(2);
        chk("disable_clears", 8'(turn_pending), 8'd0);
        do_tick(pulses);
        chk("disable_dir_held", 8'(direction), 8'd1);
        game_enable = 1'b1;
        wait_cycles(5);
        do_tick(pulses);
        chk("reenable_dir_held", 8'(direction), 8'd1);
        chk("reenable_no_pending", 8'(turn_pending), 8'd0);
        left_P = 1'b1;
        wait_cycles(10);

        // Key held through reset release must be released before it counts
        right_P = 1'b0;
        pulse_reset();
        wait_cycles(20);
        chk("held_reset_dir", 8'(direction), 8'd0);
        chk("held_reset_no_pending", 8'(turn_pending), 8'd0);
        right_P = 1'b1;
        wait_cycles(10);
        right_P = 1'b0;
        wait_cycles(8);
        chk("held_reset_repress", 8'(turn_pending), 8'd1);
        right_P = 1'b1;
        wait_cycles(10);
        do_tick(pulses);
        chk("held_reset_turn", 8'(direction), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_direction_ctrl.md
Name: key_direction_ctrl

Overview:
- Input stage directly upstream of snake_game: turns the raw DE2 pushbuttons KEY2 (right turn) and KEY3 (left turn) into a clean heading for the snake.
- Synchronises and debounces both keys, then detects presses.
- Queues at most one turn per game step and commits it on the next game_tik rising edge.
- snake_game consumes direction and dir_update instead of raw right_P/left_P.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive clock_25 cycles a synced key level must hold before it is accepted (10 ms at 25 MHz)
DEB_CNT_BIT, 18, debounce counter width; must hold DEBOUNCE_CYCLES
INIT_DIR, 2'b00, heading loaded at reset

Ports:
clock_25  in  1  system pixel clock, all logic on rising edge
reset  in  1  asynchronous active-low reset (KEY0)
game_tik  in  1  game-step signal, level; its rising edge is detected internally
game_enable  in  1  1 = play running; 0 = presses discarded, pending turn cleared
right_P  in  1  raw KEY2, active-low, asynchronous
left_P  in  1  raw KEY3, active-low, asynchronous
direction  out  2  committed heading: 00 right, 01 down, 10 left, 11 up
dir_update  out  1  one-cycle pulse when direction changes
turn_pending  out  1  1 while a turn is queued

Behaviour:
- Clocking: one clock (clock_25). Reset is asynchronous and active-low (reset port).
- Reset values:
  - direction = INIT_DIR; dir_update = 0; turn_pending = 0.
  - FSM in IDLE; debounce counters = 0.
  - Sync flops, debounced key levels and game_tik delay flop = 1 (keys released, no false edge).
- Synchronisation:
  - Each key passes through 2 flops.
  - game_tik passes through 2 flops plus 1 delay flop.
  - tick_rise = sync & ~delayed, one cycle wide.
- Debounce, per key, independent:
  - If synced level == debounced level, counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - Any bounce back clears the counter.
  - Counter saturates, never wraps.
- Press detect: debounced level 1->0 gives a one-cycle press_r / press_l. Release generates nothing. A held key gives exactly one press.
- Latency: raw key edge to press pulse = 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- FSM states: IDLE, PEND_R, PEND_L.
  - IDLE, press_r only -> PEND_R.
  - IDLE, press_l only -> PEND_L.
  - IDLE, press_r & press_l in the same cycle -> stay IDLE (ambiguous, ignored).
  - PEND_x, any press -> stay PEND_x (first press wins; extra presses dropped, no buffering).
  - PEND_x, tick_rise -> commit and return to IDLE. PEND_R: direction = direction+1 mod 4. PEND_L: direction = direction-1 mod 4.
  - dir_update = 1 in the cycle after commit, aligned with the new direction value.
  - IDLE, tick_rise -> no change, dir_update stays 0.
- Simultaneous events:
  - tick_rise and press in the same cycle while IDLE: the press is queued and commits on the following tick, never the current one.
  - tick_rise and press in the same cycle while PEND_x: commit the pending turn; the new press is dropped.
- turn_pending = (state != IDLE), registered.
- game_enable:
  - When 0: FSM forced to IDLE, presses ignored, tick_rise ignored, direction held.
  - Debounce keeps running, so a key held across re-enable does not fire a press.
- Reset mid-operation: all state returns to reset values immediately. A key held during reset release needs a full release/press cycle before it registers.
- Arithmetic: direction is 2-bit modulo. 11+1 = 00 (up -> right) and 00-1 = 11 (right -> up).

Test Plan:
- All tests use DEBOUNCE_CYCLES = 4.
- Reset/init: hold reset = 0 with keys toggling -> direction = 00, dir_update = 0, turn_pending = 0. Release reset, 20 cycles with keys at 1 -> nothing changes.
- Single right turn: right_P low for 10 cycles (game_enable = 1) -> turn_pending = 1 after 2+4+1 cycles. Next game_tik rise -> direction 00->01, dir_update high exactly 1 cycle, turn_pending = 0.
- Bounce rejection: right_P toggles every 2 cycles for 30 cycles, then stays high -> no press, turn_pending stays 0. Four left turns from reset -> direction sequence 11, 10, 01, 00 (wrap verified).
- Conflict rules:
  - Both keys fall in the same cycle -> no turn after the tick.
  - left pressed, then right pressed before the tick -> one left turn only, direction 00->11.
- Tick/press coincidence: press_r pulse in the same cycle as tick_rise from IDLE -> no change on that tick; direction 00->01 on the next tick.
- game_enable: PEND_L queued, then game_enable = 0 -> turn_pending = 0, ticks leave direction unchanged. Re-enable with the key still held -> no turn.
